// File: rtl/simd_shifter_pkg.sv
// Shared types for the SIMD shifter family plus the normalizer's
// stage counter type, FSM states and binary-search stage amounts.
package simd_shifter_pkg;

  typedef logic [31:0] word_t;

  // 2'b11 is left unnamed on purpose; consumers treat it as MODE_4B.
  typedef enum logic [1:0] {
    MODE_1B = 2'b00,
    MODE_2B = 2'b01,
    MODE_4B = 2'b10
  } mode_t;

  typedef logic [4:0] norm_cnt_t;

  // Four shift entries, entry i in bits [5i+4:5i].
  typedef norm_cnt_t [3:0] shift_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } norm_state_t;

  localparam int unsigned NUM_STAGES = 5;

  localparam norm_cnt_t STAGE_K0 = 5'd16;
  localparam norm_cnt_t STAGE_K1 = 5'd8;
  localparam norm_cnt_t STAGE_K2 = 5'd4;
  localparam norm_cnt_t STAGE_K3 = 5'd2;
  localparam norm_cnt_t STAGE_K4 = 5'd1;

  // Stage index to shift amount k; halves each stage like a binary search.
  function automatic norm_cnt_t stage_k(input logic [2:0] stage);
    case (stage)
      3'd0:    return STAGE_K0;
      3'd1:    return STAGE_K1;
      3'd2:    return STAGE_K2;
      3'd3:    return STAGE_K3;
      default: return STAGE_K4;
    endcase
  endfunction

endpackage

// File: rtl/simd_normalizer_step.sv
// One binary-search normalization stage: for each lane wider than k whose
// top k bits are all zero, shift that lane left by k and add k to its count.
module simd_normalizer_step
  import simd_shifter_pkg::*;
(
  input  mode_t      mode_i,
  input  norm_cnt_t  k_i,
  input  word_t      word_i,
  input  shift_vec_t shift_i,
  output word_t      word_o,
  output shift_vec_t shift_o
);

  // True when the top kk bits of a width-bit lane (zero-extended) are zero.
  function automatic logic lane_hit(input word_t lane, input int width, input int kk);
    return (lane >> (width - kk)) == '0;
  endfunction

  // Apply the stage to every lane of the current mode; lanes not wider than k pass through.
  always_comb begin
    word_t lane;
    int    kk;
    word_o  = word_i;
    shift_o = shift_i;
    lane    = '0;
    kk      = int'(k_i);
    case (mode_i)
      MODE_1B: begin
        if (kk < 8) begin
          for (int l = 0; l < 4; l++) begin
            lane = 32'(word_i[8*l +: 8]);
            if (lane_hit(lane, 8, kk)) begin
              word_o[8*l +: 8] = 8'(lane << kk);
              shift_o[l]       = shift_i[l] + k_i;
            end
          end
        end
      end
      MODE_2B: begin
        if (kk < 16) begin
          for (int l = 0; l < 2; l++) begin
            lane = 32'(word_i[16*l +: 16]);
            if (lane_hit(lane, 16, kk)) begin
              word_o[16*l +: 16] = 16'(lane << kk);
              shift_o[2*l]       = shift_i[2*l] + k_i;
            end
          end
        end
      end
      default: begin
        lane = word_i;
        if (lane_hit(lane, 32, kk)) begin
          word_o     = lane << kk;
          shift_o[0] = shift_i[0] + k_i;
        end
      end
    endcase
  end

endmodule

// File: rtl/simd_normalizer.sv
// SIMD leading-zero normalizer: accepts a word, runs five binary-search
// stages (16,8,4,2,1) one per cycle, then a finalize cycle that flags
// all-zero lanes before presenting the result with valid/ready.
module simd_normalizer
  import simd_shifter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_vld,
  output logic       in_rdy,
  input  word_t      in,
  input  mode_t      mode,
  output logic       out_vld,
  input  logic       out_rdy,
  output word_t      out,
  output shift_vec_t shift,
  output logic [3:0] zero
);

  norm_state_t state_q;
  logic [2:0]  stage_q;
  word_t       work_q;
  mode_t       mode_q;
  shift_vec_t  shift_q;
  logic [3:0]  zero_q;
  logic        outVld_q;

  word_t       work_d;
  shift_vec_t  shift_d;
  logic [3:0]  laneZero;

  simd_normalizer_step u_step (
    .mode_i  (mode_q),
    .k_i     (stage_k(stage_q)),
    .word_i  (work_q),
    .shift_i (shift_q),
    .word_o  (work_d),
    .shift_o (shift_d)
  );

  // Per-entry all-zero detection on the working word; shifting never changes zero-ness.
  always_comb begin
    laneZero = '0;
    case (mode_q)
      MODE_1B: begin
        for (int l = 0; l < 4; l++) laneZero[l] = (work_q[8*l +: 8] == '0);
      end
      MODE_2B: begin
        laneZero[0] = (work_q[15:0]  == '0);
        laneZero[2] = (work_q[31:16] == '0);
      end
      default: laneZero[0] = (work_q == '0);
    endcase
  end

  // FSM, stage counter and working registers; out_vld rises on the finalize edge after stage 4.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      stage_q  <= '0;
      work_q   <= '0;
      mode_q   <= MODE_4B;
      shift_q  <= '0;
      zero_q   <= '0;
      outVld_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_vld) begin
            work_q  <= in;
            mode_q  <= mode;
            shift_q <= '0;
            zero_q  <= '0;
            stage_q <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          work_q  <= work_d;
          shift_q <= shift_d;
          if (stage_q == 3'(NUM_STAGES - 1)) begin
            stage_q <= '0;
            state_q <= ST_DONE;
          end else begin
            stage_q <= stage_q + 3'd1;
          end
        end
        ST_DONE: begin
          if (!outVld_q) begin
            zero_q   <= laneZero;
            outVld_q <= 1'b1;
            for (int e = 0; e < 4; e++) begin
              if (laneZero[e]) shift_q[e] <= '0;
            end
          end else if (out_rdy) begin
            outVld_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_rdy  = (state_q == ST_IDLE) && !rst;
  assign out_vld = outVld_q;
  assign out     = work_q;
  assign shift   = shift_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_simd_normalizer.sv
// Directed and randomized checks of simd_normalizer: lane results, latency,
// backpressure hold, mid-flight reset and a shift-back round trip.
module tb_simd_normalizer;
  import simd_shifter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       inVld;
  logic       inRdy;
  word_t      inWord;
  mode_t      mode;
  logic       outVld;
  logic       outRdy;
  word_t      outWord;
  shift_vec_t shiftVec;
  logic [3:0] zeroVec;

  int testsRun = 0;
  int failures = 0;

  simd_normalizer dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (inVld),
    .in_rdy  (inRdy),
    .in      (inWord),
    .mode    (mode),
    .out_vld (outVld),
    .out_rdy (outRdy),
    .out     (outWord),
    .shift   (shiftVec),
    .zero    (zeroVec)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference normalizer: counts leading zeros bit by bit per lane.
  function automatic void modelNorm(input word_t w, input logic [1:0] m,
                                    output word_t o, output logic [19:0] s, output logic [3:0] z);
    int wd, nl, step, sh;
    word_t mask, lane;
    wd   = (m == 2'b00) ? 8 : (m == 2'b01) ? 16 : 32;
    nl   = 32 / wd;
    step = (m == 2'b00) ? 1 : 2;
    mask = (wd == 32) ? 32'hFFFF_FFFF : ((32'd1 << wd) - 32'd1);
    o = '0; s = '0; z = '0;
    for (int l = 0; l < nl; l++) begin
      lane = (w >> (l * wd)) & mask;
      sh = 0;
      if (lane == '0) z[l * step] = 1'b1;
      else begin
        while (lane[wd - 1] == 1'b0) begin
          lane = lane << 1;
          sh++;
        end
      end
      o = o | ((lane & mask) << (l * wd));
      s[l * step * 5 +: 5] = 5'(sh);
    end
  endfunction

  // Send one word, check latency and result, hold backpressure, then complete the handshake.
  task automatic applyStimulus(input word_t w, input mode_t m, input word_t expOut,
                               input logic [19:0] expShift, input logic [3:0] expZero,
                               input int holdCycles, input string tag);
    int edges;
    int waitCnt;
    @(negedge clk);
    inWord = w; mode = m; inVld = 1'b1;
    waitCnt = 0;
    while (!inRdy && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!inRdy) begin
      checkOutput({tag, "_acceptTimeout"}, 32'd0, 32'd1);
      inVld = 1'b0;
      return;
    end
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    inVld = 1'b0;
    inWord = 32'hDEAD_BEEF;
    mode = MODE_1B;
    while (!outVld && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checkOutput({tag, "_latency"}, 32'(edges), 32'd6);
    if (!outVld) return;
    checkOutput({tag, "_out"}, outWord, expOut);
    checkOutput({tag, "_shift"}, 32'(shiftVec), 32'(expShift));
    checkOutput({tag, "_zero"}, 32'(zeroVec), 32'(expZero));
    for (int c = 0; c < holdCycles; c++) begin
      @(negedge clk);
      checkOutput({tag, "_holdVld"}, 32'(outVld), 32'd1);
      checkOutput({tag, "_holdRdy"}, 32'(inRdy), 32'd0);
      checkOutput({tag, "_holdOut"}, outWord, expOut);
      checkOutput({tag, "_holdShift"}, 32'(shiftVec), 32'(expShift));
      checkOutput({tag, "_holdZero"}, 32'(zeroVec), 32'(expZero));
    end
    checkOutput({tag, "_doneInRdy"}, 32'(inRdy), 32'd0);
    outRdy = 1'b1;
    @(negedge clk);
    outRdy = 1'b0;
    checkOutput({tag, "_idleVld"}, 32'(outVld), 32'd0);
    checkOutput({tag, "_idleRdy"}, 32'(inRdy), 32'd1);
  endtask

  initial begin
    word_t       mOut, rebuilt, w;
    logic [19:0] mShift;
    logic [3:0]  mZero;
    logic [1:0]  rm;
    int          badMsb, wd, nl, step, sawVld;
    word_t       mask, lane;

    rst = 1'b1; inVld = 1'b0; inWord = '0; mode = MODE_1B; outRdy = 1'b0;
    @(negedge clk);
    checkOutput("rstInRdy", 32'(inRdy), 32'd0);
    @(negedge clk);
    checkOutput("rstOutVld", 32'(outVld), 32'd0);
    checkOutput("rstOut", outWord, 32'd0);
    checkOutput("rstShift", 32'(shiftVec), 32'd0);
    checkOutput("rstZero", 32'(zeroVec), 32'd0);
    rst = 1'b0;
    #1 checkOutput("postRstInRdy", 32'(inRdy), 32'd1);

    applyStimulus(32'h0180_000F, MODE_1B, 32'h8080_00F0, {5'd7, 5'd0, 5'd0, 5'd4}, 4'b0010, 0, "b1");
    applyStimulus(32'h0000_0001, MODE_1B, 32'h0000_0080, {5'd0, 5'd0, 5'd0, 5'd7}, 4'b1110, 0, "b1lsb");
    applyStimulus(32'hFFFF_FFFF, MODE_1B, 32'hFFFF_FFFF, 20'd0, 4'b0000, 0, "b1full");
    applyStimulus(32'h0001_4000, MODE_2B, 32'h8000_8000, {5'd0, 5'd15, 5'd0, 5'd1}, 4'b0000, 0, "b2");
    applyStimulus(32'h0000_0003, MODE_2B, 32'h0000_C000, {5'd0, 5'd0, 5'd0, 5'd14}, 4'b0100, 0, "b2zero");
    applyStimulus(32'h0000_0001, MODE_4B, 32'h8000_0000, {5'd0, 5'd0, 5'd0, 5'd31}, 4'b0000, 0, "b4one");
    applyStimulus(32'h0000_0000, MODE_4B, 32'h0000_0000, 20'd0, 4'b0001, 0, "b4zero");
    applyStimulus(32'h00F0_0000, mode_t'(2'b11), 32'hF000_0000, {5'd0, 5'd0, 5'd0, 5'd8}, 4'b0000, 0, "m11");
    applyStimulus(32'h0180_000F, MODE_1B, 32'h8080_00F0, {5'd7, 5'd0, 5'd0, 5'd4}, 4'b0010, 10, "bp");

    // Reset during the third BUSY cycle drops the word entirely.
    @(negedge clk);
    inWord = 32'h0000_00FF; mode = MODE_4B; inVld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inVld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("midRstInRdy", 32'(inRdy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstOutVld", 32'(outVld), 32'd0);
    checkOutput("midRstOut", outWord, 32'd0);
    checkOutput("midRstShift", 32'(shiftVec), 32'd0);
    #1 checkOutput("midRstInRdyBack", 32'(inRdy), 32'd1);
    sawVld = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (outVld) sawVld = 1;
    end
    checkOutput("midRstNoOutput", 32'(sawVld), 32'd0);
    applyStimulus(32'h0000_00FF, MODE_4B, 32'hFF00_0000, {5'd0, 5'd0, 5'd0, 5'd24}, 4'b0000, 0, "afterRst");

    // Randomized words checked against the model and by shifting back.
    for (int t = 0; t < 12; t++) begin
      rm = 2'($urandom_range(0, 3));
      w  = $urandom >> $urandom_range(0, 31);
      if (t % 3 == 0) w = w & ~(32'hFF << (8 * $urandom_range(0, 3)));
      modelNorm(w, rm, mOut, mShift, mZero);
      applyStimulus(w, mode_t'(rm), mOut, mShift, mZero, 0, "rand");
      wd   = (rm == 2'b00) ? 8 : (rm == 2'b01) ? 16 : 32;
      nl   = 32 / wd;
      step = (rm == 2'b00) ? 1 : 2;
      mask = (wd == 32) ? 32'hFFFF_FFFF : ((32'd1 << wd) - 32'd1);
      rebuilt = '0;
      badMsb  = 0;
      for (int l = 0; l < nl; l++) begin
        lane = (mOut >> (l * wd)) & mask;
        rebuilt = rebuilt | ((lane >> mShift[l * step * 5 +: 5]) << (l * wd));
        if (lane != '0 && lane[wd - 1] == 1'b0) badMsb++;
      end
      checkOutput("roundTrip", rebuilt, w);
      checkOutput("msbSet", 32'(badMsb), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/simd_normalizer.md
SIMD_NORMALIZER -- requirements
Module: simd_normalizer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports listed in this order:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-002 SHALL accept input through these ports:
- in_vld  in  1  input word valid.
- in_rdy  out  1  block can accept an input word.
- in  in  32  data word, as simd_shifter_pkg::word_t.
- mode  in  2  lane mode, as simd_shifter_pkg::mode_t.
REQ-003 SHALL return results through these ports:
- out_vld  out  1  result valid.
- out_rdy  in  1  downstream accepts the result.
- out  out  32  normalized word.
- shift  out  4x5  per-lane left-shift amount applied.
- zero  out  4  per-lane flag: lane input was all zeros.
REQ-004 SHALL decode lane modes as follows:
- MODE_1B: 4 lanes of 8 bits; lane i is bits [8i+7:8i].
- MODE_2B: 2 lanes of 16 bits.
- MODE_4B: 1 lane of 32 bits.
- Encoding 2'b11: treated as MODE_4B.

Function
REQ-005 SHALL left-shift each lane independently until the lane MSB is 1, and report the shift amount per lane.
REQ-006 SHALL map shift and zero entries to lanes as follows; all other entries read 0:
- MODE_1B: entry i holds lane i.
- MODE_2B: entries 0 and 2 hold lanes 0 and 1.
- MODE_4B: entry 0 holds the lane.
REQ-007 SHALL use a 3-state FSM: IDLE, BUSY, DONE.
REQ-008 SHALL drive in_rdy=1 only in IDLE with rst low, and drive out_vld=1 only in DONE.
REQ-009 SHALL, in IDLE, on in_vld&&in_rdy: capture in and mode into working registers, clear shift and zero, clear the stage counter, and go to BUSY.
REQ-010 SHALL perform one binary-search stage per BUSY cycle with k = 16, 8, 4, 2, 1 (stage counter 0..4).
REQ-011 SHALL, in each stage and for each lane with k < lane width: if the top k bits of the lane are all zero, shift the lane left by k with zero fill and add k to the lane's shift entry; otherwise leave the lane unchanged.
REQ-012 SHALL leave lanes untouched in stages where k >= lane width.
REQ-013 SHALL leave the working registers unchanged when mode is sampled mid-BUSY; only the mode captured at acceptance governs.
REQ-014 SHALL, on the edge completing stage 4, go to DONE.
- out_vld rises exactly 6 edges after the accepting edge.
- Latency is independent of mode and data.
REQ-015 SHALL flag an all-zero lane input with zero=1, shift=0 and lane output 0, overriding any accumulated shift.
REQ-016 SHALL hold out, shift and zero stable in DONE until out_vld&&out_rdy, then go to IDLE.
REQ-017 SHALL keep in_rdy=0 on the DONE→IDLE transition edge; no accept occurs that cycle.
REQ-018 SHALL guarantee shift per lane ≤ lane width−1, so 5 bits always suffice.
REQ-019 SHALL ignore in_vld outside IDLE and ignore out_rdy outside DONE.

Reset
REQ-020 SHALL, while rst is high at an edge, force state IDLE, out_vld=0, out=0, shift=0, zero=0 and stage counter=0.
REQ-021 SHALL, when rst asserts in BUSY or DONE, abandon the in-flight word and produce no output for it.
REQ-022 SHALL hold in_rdy=0 while rst is high and raise it in the first cycle after rst deasserts.

Structure
REQ-023 SHALL reuse word_t and mode_t from simd_shifter_pkg.
REQ-024 SHALL add to simd_shifter_pkg: norm_cnt_t (5-bit), the state enum, and the stage-amount constants.
REQ-025 SHALL implement one combinational sub-module, simd_normalizer_step, that applies a single stage k to the word and counts given the mode; the top level holds the FSM, counter and registers.

Verification
REQ-026 SHALL cover the following directed scenarios:
- MODE_1B, in=32'h0180000F -> out=32'h8080_00F0, shift={7,0,0,4} for lanes {3,2,1,0}, zero=4'b0010.
- MODE_2B, in=32'h0001_4000 -> out=32'h8000_8000, shift[0]=1, shift[2]=15, shift[1]=shift[3]=0, zero=0.
- MODE_4B: in=32'h0000_0001 -> out=32'h8000_0000, shift[0]=31; in=0 -> out=0, shift[0]=0, zero=4'b0001.
- Backpressure: hold out_rdy=0 for 10 cycles in DONE -> out, shift and zero stable, in_rdy=0; then accept -> IDLE next cycle; out_vld rises exactly 6 edges after each accept.
- Reset at the 3rd BUSY cycle -> out_vld never rises for that word; the next word completes with correct values.
- Random round trip: for each nonzero lane, logically shifting out right by shift reproduces in; every nonzero lane output has its MSB set.
